// File: rtl/ram256_pkg.sv
// Shared definitions for the 256x64 RAM read path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: RAM geometry, reader FSM state encoding, FIFO beat layout, length clamp.
package ram256_pkg;

  localparam int RAM_AW      = 8;
  localparam int RAM_DW      = 64;
  localparam int RAM_ADDR_W  = 64;
  localparam int RAM_IDX_MSB = 63;
  localparam int RAM_IDX_LSB = 56;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  // One buffered beat: payload plus the tags it is streamed with.
  typedef struct packed {
    logic [RAM_DW-1:0] data;
    logic [RAM_AW-1:0] idx;
    logic              last;
  } beat_t;

  // A burst can never cover more than the whole RAM.
  function automatic logic [8:0] clamp_len(input logic [8:0] len);
    return (len > 9'd256) ? 9'd256 : len;
  endfunction

endpackage

// File: rtl/ram_burst_reader_if.sv
// Valid/ready beat stream carrying RAM payload, source index and last flag.
// Latency: n/a (wires only).
// Backpressure: a beat moves only when valid & ready; the source holds it otherwise.
// Ports: master drives valid/data/idx/last and samples ready; slave is the reverse.
interface ram_burst_reader_if;
  import ram256_pkg::*;

  logic              valid;
  logic              ready;
  logic [RAM_DW-1:0] data;
  logic [RAM_AW-1:0] idx;
  logic              last;

  modport master (output valid, data, idx, last, input ready);
  modport slave  (input valid, data, idx, last, output ready);

endinterface

// File: rtl/ram_burst_reader_rd_fifo.sv
// Synchronous FIFO holding read beats between RAM capture and the output stream.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must never push when full.
// Ports: clk/rst_n, push/push_dat, pop, head (current front entry), full/empty/count.
module rd_fifo
  import ram256_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  beat_t         push_dat,
  input  logic          pop,
  output beat_t         head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  beat_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage is reset too, so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/ram_burst_reader.sv
// Reads burst_len consecutive RAM entries from base_idx (wrapping mod 256) onto a beat stream.
// Latency: start at edge E0 -> first ram_addr in cycle 1 -> first m.valid in cycle RD_LAT+2.
// Backpressure: reads are credit-limited by the output FIFO, so stalls never drop data.
// Ports: clk/rst_n; start/base_idx/burst_len request; busy/done status;
//        ram_addr/ram_wrt/ram_data_in/ram_data_out RAM side; m stream (valid/ready/data/idx/last).
module ram_burst_reader
  import ram256_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [RAM_AW-1:0]     base_idx,
  input  logic [8:0]            burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_wrt,
  output logic [RAM_DW-1:0]     ram_data_in,
  input  logic [RAM_DW-1:0]     ram_data_out,
  ram_burst_reader_if.master    m
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t            state;
  state_t            state_nxt;
  logic [RAM_AW-1:0] idx_q;
  logic [8:0]        rem_q;
  logic [CW-1:0]     inflight_q;
  logic [CW-1:0]     fifo_count;
  logic              done_zero_q;
  logic [8:0]        len_c;
  logic              credit_ok;
  logic              issue;
  logic              issue_last;
  logic              cap_vld;
  logic [RAM_AW-1:0] cap_idx;
  logic              cap_last;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  beat_t             head;
  beat_t             cap_beat;

  assign len_c = clamp_len(burst_len);

  // Buffered beats plus reads still in the RAM pipe must fit in the FIFO.
  // The full check is implied by the sum; it is kept as a cheap extra guard.
  assign credit_ok  = !fifo_full &&
                      (({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW + 1)'(FIFO_DEPTH));
  assign issue      = (state == ISSUE) && credit_ok;
  assign issue_last = (rem_q == 9'd1);
  assign pop        = m.valid && m.ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (len_c != 9'd0)) state_nxt = ISSUE;
      ISSUE:   if (issue && issue_last)      state_nxt = DRAIN;
      DRAIN:   if (pop && head.last)         state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy     = (state != IDLE);
    ram_addr = '0;
    if (state == ISSUE) ram_addr[RAM_IDX_MSB:RAM_IDX_LSB] = idx_q;
    // Zero-length request pulses a cycle late; a real burst ends on its last beat.
    done     = done_zero_q || ((state == DRAIN) && pop && head.last);
  end

  // ---------------- index / remaining / credit counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      rem_q       <= '0;
      done_zero_q <= 1'b0;
      inflight_q  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        idx_q <= base_idx;
        rem_q <= len_c;
      end else if (issue) begin
        idx_q <= idx_q + 1'b1;   // 8-bit wrap gives 255 -> 0
        rem_q <= rem_q - 1'b1;
      end
      done_zero_q <= (state == IDLE) && start && (len_c == 9'd0);
      case ({issue, cap_vld})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // ---------------- tag delay line matching the RAM read latency ----------------
  generate
    if (RD_LAT == 0) begin : g_nolat
      assign cap_vld  = issue;
      assign cap_idx  = idx_q;
      assign cap_last = issue && issue_last;
    end else begin : g_lat
      logic [RD_LAT-1:0] vld_pipe;
      logic [RD_LAT-1:0] last_pipe;
      logic [RAM_AW-1:0] idx_pipe [RD_LAT];

      // Clearing on reset drops any read whose data is still in the RAM.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe  <= '0;
          last_pipe <= '0;
          for (int i = 0; i < RD_LAT; i++) idx_pipe[i] <= '0;
        end else begin
          vld_pipe[0]  <= issue;
          last_pipe[0] <= issue && issue_last;
          idx_pipe[0]  <= idx_q;
          for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            last_pipe[i] <= last_pipe[i-1];
            idx_pipe[i]  <= idx_pipe[i-1];
          end
        end
      end

      assign cap_vld  = vld_pipe[RD_LAT-1];
      assign cap_idx  = idx_pipe[RD_LAT-1];
      assign cap_last = last_pipe[RD_LAT-1];
    end
  endgenerate

  assign cap_beat = '{data: ram_data_out, idx: cap_idx, last: cap_last};

  rd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cap_vld),
    .push_dat (cap_beat),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Head of the FIFO is held until popped, so the beat is stable under stall.
  assign m.valid = !fifo_empty;
  assign m.data  = head.data;
  assign m.idx   = head.idx;
  assign m.last  = head.last;

  assign ram_wrt     = 1'b0;
  assign ram_data_in = '0;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a RAM model, a ready driver and a beat scoreboard.
module tb_ram_burst_reader;
  import ram256_pkg::*;

  localparam int RD_LAT = 1;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_idx = '0;
  logic [8:0]  burst_len = '0;
  logic        busy, done, ram_wrt;
  logic [63:0] ram_addr, ram_data_in, ram_data_out;

  ram_burst_reader_if m();

  ram_burst_reader #(.RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_idx     (base_idx),
    .burst_len    (burst_len),
    .busy         (busy),
    .done         (done),
    .ram_addr     (ram_addr),
    .ram_wrt      (ram_wrt),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .m            (m)
  );

  always #5 clk = ~clk;

  // RAM model with one cycle of read latency.
  logic [63:0] mem [256];
  logic [63:0] ram_q = '0;
  always @(posedge clk) ram_q <= mem[ram_addr[63:56]];
  assign ram_data_out = ram_q;

  typedef struct packed {
    logic [7:0]  idx;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   beats = 0;
  int   done_cnt = 0;
  int   first_cyc = 0;
  int   start_mark = 0;
  int   rdy_mode = 0;    // 0: always ready, 1: never ready, 2: random
  bit   arm = 0;
  bit   valid_seen = 0;
  bit   busy_seen = 0;
  bit   pv_stall = 0;
  logic [63:0] pdata;
  logic [7:0]  pidx;
  logic        plast;

  // Ready driver: changes just after the rising edge.
  initial begin
    m.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m.ready = 1'b1;
        1:       m.ready = 1'b0;
        default: m.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (done)    done_cnt++;
      if (m.valid) valid_seen = 1;
      if (busy)    busy_seen = 1;
      if (arm && m.valid) begin
        first_cyc = cyc;
        arm = 0;
      end
      total++;
      assert (dut.fifo_count <= DEPTH) else begin
        bad++;
        $error("FAIL fifo_bound observed=%0d expected<=%0d", dut.fifo_count, DEPTH);
      end
      total++;
      assert (ram_wrt === 1'b0 && ram_data_in === 64'h0) else begin
        bad++;
        $error("FAIL ram_write_tied observed=%b/%0h expected=0/0", ram_wrt, ram_data_in);
      end
      if (pv_stall) begin
        total++;
        assert (m.valid === 1'b1 && m.data === pdata && m.idx === pidx && m.last === plast) else begin
          bad++;
          $error("FAIL stall_stable observed=%b/%0h/%0h/%b expected=1/%0h/%0h/%b",
                 m.valid, m.data, m.idx, m.last, pdata, pidx, plast);
        end
      end
      if (m.valid && m.ready) begin
        beats++;
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL extra_beat observed idx=%0h expected=no beat", m.idx);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          total++;
          assert (m.idx === e.idx && m.data === e.data && m.last === e.last) else begin
            bad++;
            $error("FAIL beat observed=%0h/%0h/%b expected=%0h/%0h/%b",
                   m.idx, m.data, m.last, e.idx, e.data, e.last);
          end
          if (e.last) begin
            total++;
            assert (done === 1'b1) else begin
              bad++;
              $error("FAIL done_on_last observed=%b expected=1", done);
            end
          end
        end
      end
      pv_stall = m.valid && !m.ready;
      pdata    = m.data;
      pidx     = m.idx;
      plast    = m.last;
    end else begin
      pv_stall = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start and pushes the beats the request should produce.
  task automatic launch(input logic [7:0] b, input logic [8:0] l, input bit expect_beats);
    int n;
    logic [7:0] ix;
    n = (l > 9'd256) ? 256 : int'(l);
    if (expect_beats) begin
      for (int i = 0; i < n; i++) begin
        ix = b + 8'(i);
        sb.push_back('{idx: ix, data: mem[ix], last: (i == n - 1)});
      end
      arm = (n != 0);
    end
    start_mark = cyc + 1;
    start      = 1'b1;
    base_idx   = b;
    burst_len  = l;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    chk(tag, 64'(i < budget), 64'd1);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  64'(busy),    64'd0);
    chk({tag, "_done"},  64'(done),    64'd0);
    chk({tag, "_addr"},  ram_addr,     64'd0);
    chk({tag, "_valid"}, 64'(m.valid), 64'd0);
    chk({tag, "_data"},  m.data,       64'd0);
    chk({tag, "_idx"},   64'(m.idx),   64'd0);
    chk({tag, "_last"},  64'(m.last),  64'd0);
  endtask

  initial begin
    int d0, b0;
    for (int i = 0; i < 256; i++) mem[i] = 64'(i) * 64'h0101;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: basic burst, full throughput
    d0 = done_cnt; b0 = beats;
    launch(8'h10, 9'd4, 1);
    chk("t1_busy_after_start", 64'(busy), 64'd1);
    wait_idle("t1_complete", 50);
    chk("t1_first_valid_lat", 64'(first_cyc - start_mark), 64'(RD_LAT + 2));
    chk("t1_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t1_beats", 64'(beats - b0), 64'd4);

    // 2: index wrap 255 -> 0
    b0 = beats;
    launch(8'hFE, 9'd4, 1);
    wait_idle("t2_complete", 50);
    chk("t2_beats", 64'(beats - b0), 64'd4);

    // 3: full-RAM burst under random back-pressure
    rdy_mode = 2;
    b0 = beats;
    launch(8'h37, 9'd256, 1);
    wait_idle("t3_complete", 3000);
    chk("t3_beats", 64'(beats - b0), 64'd256);
    rdy_mode = 0;
    tick();

    // 4: zero-length request, then clamp of an oversize length
    d0 = done_cnt;
    valid_seen = 0;
    busy_seen = 0;
    launch(8'h20, 9'd0, 0);
    chk("t4_len0_done_next_cycle", 64'(done), 64'd1);
    repeat (10) tick();
    chk("t4_len0_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t4_len0_no_valid", 64'(valid_seen), 64'd0);
    chk("t4_len0_no_busy", 64'(busy_seen), 64'd0);
    b0 = beats;
    launch(8'h80, 9'd300, 1);
    wait_idle("t4_clamp_complete", 1000);
    chk("t4_clamp_beats", 64'(beats - b0), 64'd256);

    // 5: start while busy is ignored
    rdy_mode = 2;
    d0 = done_cnt; b0 = beats;
    launch(8'h40, 9'd16, 1);
    repeat (4) tick();
    start = 1'b1; base_idx = 8'h99; burst_len = 9'd5;
    tick();
    start = 1'b0;
    wait_idle("t5_complete", 500);
    chk("t5_beats", 64'(beats - b0), 64'd16);
    chk("t5_done_count", 64'(done_cnt - d0), 64'd1);

    //    reset in the middle of a burst
    launch(8'h00, 9'd32, 1);
    repeat (8) tick();
    d0 = done_cnt;
    rst_n = 1'b0;
    sb.delete();
    arm = 0;
    tick();
    chk_reset_outputs("t5_midreset");
    tick();
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (3) tick();
    chk("t5_no_done_after_reset", 64'(done_cnt - d0), 64'd0);
    chk("t5_no_valid_after_reset", 64'(m.valid), 64'd0);
    d0 = done_cnt; b0 = beats;
    launch(8'hC0, 9'd8, 1);
    wait_idle("t5_after_reset_complete", 100);
    chk("t5_after_reset_beats", 64'(beats - b0), 64'd8);
    chk("t5_after_reset_done", 64'(done_cnt - d0), 64'd1);

    // 6: long stall, credit limit, then drain
    rdy_mode = 1;
    tick();
    tick();
    b0 = beats;
    launch(8'h50, 9'd8, 1);
    repeat (19) tick();
    chk("t6_fifo_full", 64'(dut.fifo_count), 64'(DEPTH));
    chk("t6_issue_stopped_rem", 64'(dut.rem_q), 64'(8 - DEPTH));
    chk("t6_head_idx", 64'(m.idx), 64'h50);
    chk("t6_valid_held", 64'(m.valid), 64'd1);
    rdy_mode = 0;
    wait_idle("t6_complete", 100);
    chk("t6_beats", 64'(beats - b0), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
